// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus per-channel stability counter
// for the slide switches. Presents a clean level per switch and single-cycle
// rise/fall pulses for each accepted transition.
module switch_debouncer #(
   parameter int unsigned NUM_SWITCHES    = 6,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_SWITCHES-1:0] i_switch,
   output logic [NUM_SWITCHES-1:0] o_switch,
   output logic [NUM_SWITCHES-1:0] o_rise,
   output logic [NUM_SWITCHES-1:0] o_fall
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SWITCHES-1:0]            sync1;
   logic [NUM_SWITCHES-1:0]            sync2;
   logic [NUM_SWITCHES-1:0]            stable;
   logic [NUM_SWITCHES-1:0]            stable_nxt;
   logic [NUM_SWITCHES-1:0]            rise_nxt;
   logic [NUM_SWITCHES-1:0]            fall_nxt;
   logic [NUM_SWITCHES-1:0][CNT_W-1:0] cnt;
   logic [NUM_SWITCHES-1:0][CNT_W-1:0] cnt_nxt;

   // Two-flop synchroniser; only sync2 is used past this point.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= i_switch;
         sync2 <= sync1;
      end
   end

   // Per-channel debounce: count consecutive disagreeing cycles, accept on the last one.
   always_comb begin
      stable_nxt = stable;
      cnt_nxt    = cnt;
      rise_nxt   = '0;
      fall_nxt   = '0;
      for (int n = 0; n < int'(NUM_SWITCHES); n++) begin
         if (sync2[n] == stable[n]) begin
            cnt_nxt[n] = '0;
         end else if (cnt[n] < CNT_LAST) begin
            cnt_nxt[n] = cnt[n] + CNT_W'(1);
         end else begin
            stable_nxt[n] = sync2[n];
            cnt_nxt[n]    = '0;
            rise_nxt[n]   = sync2[n];
            fall_nxt[n]   = ~sync2[n];
         end
      end
   end

   // Channel state and pulse registers; reset discards any partial count.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         stable <= '0;
         cnt    <= '0;
         o_rise <= '0;
         o_fall <= '0;
      end else begin
         stable <= stable_nxt;
         cnt    <= cnt_nxt;
         o_rise <= rise_nxt;
         o_fall <= fall_nxt;
      end
   end

   assign o_switch = stable;

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer: directed scenarios plus random bouncing,
// all checked every cycle against a window-based reference model.
module tb_switch_debouncer;

   localparam int unsigned N = 6;
   localparam int unsigned D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] sw;
   logic [N-1:0] o_switch;
   logic [N-1:0] o_rise;
   logic [N-1:0] o_fall;

   int total = 0;
   int bad   = 0;

   // Reference model: a new level is accepted once the last D synchronised
   // samples (since reset) all disagree with the current accepted level.
   logic [N-1:0] m_s1     = '0;
   logic [N-1:0] m_s2     = '0;
   logic [N-1:0] m_stable = '0;
   logic [N-1:0] m_rise   = '0;
   logic [N-1:0] m_fall   = '0;
   logic [N-1:0] hist[$];

   always #5 clk = ~clk;

   switch_debouncer #(
      .NUM_SWITCHES   (N),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_switch(sw),
      .o_switch(o_switch),
      .o_rise  (o_rise),
      .o_fall  (o_fall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic [N-1:0] s);
      logic all_diff;
      if (!r) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
         hist.delete();
      end else begin
         hist.push_back(m_s2);
         if (hist.size() > D) void'(hist.pop_front());
         m_rise = '0;
         m_fall = '0;
         if (hist.size() == D) begin
            for (int n = 0; n < int'(N); n++) begin
               all_diff = 1'b1;
               for (int k = 0; k < int'(D); k++)
                  if (hist[k][n] == m_stable[n]) all_diff = 1'b0;
               if (all_diff) begin
                  m_stable[n] = ~m_stable[n];
                  if (m_stable[n]) m_rise[n] = 1'b1;
                  else             m_fall[n] = 1'b1;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = s;
      end
   endtask

   // One clock: drive on negedge, update model at posedge, compare 1 time unit later.
   task automatic step(input logic r, input logic [N-1:0] s);
      @(negedge clk);
      rst_n = r;
      sw    = s;
      @(posedge clk);
      model_update(r, s);
      #1;
      check("level", 32'(o_switch), 32'(m_stable));
      check("rise",  32'(o_rise),   32'(m_rise));
      check("fall",  32'(o_fall),   32'(m_fall));
   endtask

   initial begin
      int           rise_cnt;
      logic         r;
      logic [N-1:0] cur;
      rst_n = 1'b0;
      sw    = '0;

      // Reset with all switches high, then release: all rise at E0+5.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '1);
         check("rst_hold_level", 32'(o_switch), 32'd0);
      end
      for (int i = 0; i <= 6; i++) begin
         step(1'b1, '1);
         check("rst_rel_level", 32'(o_switch), (i >= 5) ? 32'h3f : 32'h0);
         check("rst_rel_rise",  32'(o_rise),   (i == 5) ? 32'h3f : 32'h0);
         check("rst_rel_fall",  32'(o_fall),   32'h0);
      end

      // Return to a clean all-low state.
      step(1'b0, '0);
      for (int i = 0; i < 4; i++) step(1'b1, '0);

      // Clean rise on switch 0.
      for (int i = 0; i <= 6; i++) begin
         step(1'b1, 6'b000001);
         check("clean_level", 32'(o_switch), (i >= 5) ? 32'h1 : 32'h0);
         check("clean_rise",  32'(o_rise),   (i == 5) ? 32'h1 : 32'h0);
      end

      // Glitch on switch 2 shorter than the debounce window.
      for (int i = 0; i < 3; i++) step(1'b1, 6'b000101);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 6'b000001);
         check("glitch_level", 32'(o_switch[2]), 32'd0);
         check("glitch_pulse", 32'(o_rise[2] | o_fall[2]), 32'd0);
      end

      // Bounce on switch 1 then settle high: exactly one rise, 5 edges after final 0->1.
      rise_cnt = 0;
      step(1'b1, 6'b000011); rise_cnt += int'(o_rise[1]);
      step(1'b1, 6'b000001); rise_cnt += int'(o_rise[1]);
      step(1'b1, 6'b000011); rise_cnt += int'(o_rise[1]);
      step(1'b1, 6'b000011); rise_cnt += int'(o_rise[1]);
      step(1'b1, 6'b000001); rise_cnt += int'(o_rise[1]);
      for (int i = 0; i <= 7; i++) begin
         step(1'b1, 6'b000011);
         rise_cnt += int'(o_rise[1]);
         check("bounce_level", 32'(o_switch[1]), (i >= 5) ? 32'd1 : 32'd0);
      end
      check("bounce_rise_count", 32'(rise_cnt), 32'd1);

      // Simultaneous opposite transitions from 000011 to 001100.
      for (int i = 0; i <= 6; i++) begin
         step(1'b1, 6'b001100);
         check("simul_level", 32'(o_switch), (i >= 5) ? 32'h0c : 32'h03);
         check("simul_rise",  32'(o_rise),   (i == 5) ? 32'h0c : 32'h00);
         check("simul_fall",  32'(o_fall),   (i == 5) ? 32'h03 : 32'h00);
      end

      // Switch 5 rises; reset when its count reaches 2, then release.
      for (int i = 0; i < 4; i++) step(1'b1, 6'b101100);
      step(1'b0, 6'b101100);
      check("midrst_level", 32'(o_switch), 32'h0);
      for (int i = 0; i <= 6; i++) begin
         step(1'b1, 6'b101100);
         check("midrst_rel_level", 32'(o_switch), (i >= 5) ? 32'h2c : 32'h0);
         check("midrst_rel_rise",  32'(o_rise),   (i == 5) ? 32'h2c : 32'h0);
      end

      // Random bouncing with occasional resets.
      cur = 6'b101100;
      for (int c = 0; c < 4000; c++) begin
         r = ($urandom_range(0, 299) != 0);
         for (int n = 0; n < int'(N); n++)
            if ($urandom_range(0, 6) == 0) cur[n] = ~cur[n];
         step(r, cur);
         check("onehot_pulse", 32'(o_rise & o_fall), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronises and debounces the Basys3 slide switches before they drive the switch-to-LED logic. Each raw switch input goes through a two-flop synchroniser and a per-channel stability counter. The block presents a clean level per switch, plus single-cycle rise and fall pulses. It sits directly upstream of the LED mapping stage and replaces its raw switch inputs.

## Interface
Parameters:
- NUM_SWITCHES, 6, number of independent switch channels (1..16)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before accepting a new level (10 ms at 100 MHz); must be >= 2

Ports:
- i_clk  input  1  system clock, 100 MHz on Basys3
- i_rst_n  input  1  synchronous active-low reset, sampled on rising edge of i_clk
- i_switch  input  NUM_SWITCHES  raw asynchronous switch levels, bit n = switch n
- o_switch  output  NUM_SWITCHES  debounced switch levels, registered
- o_rise  output  NUM_SWITCHES  one-cycle pulse when o_switch[n] goes 0->1
- o_fall  output  NUM_SWITCHES  one-cycle pulse when o_switch[n] goes 1->0

## Operation
- Synchroniser:
  - Per bit: sync1 <= i_switch, then sync2 <= sync1.
  - Only sync2 is used downstream.
- Per-channel state:
  - stable[n] drives o_switch[n].
  - cnt[n] is $clog2(DEBOUNCE_CYCLES) bits wide, unsigned.
- Per clock edge, for each channel independently:
  - sync2 == stable: cnt <= 0 and no output change. This is how glitches shorter than DEBOUNCE_CYCLES are discarded.
  - sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0. On the same edge, o_rise or o_fall is registered high according to the new value.
- Pulses:
  - o_rise and o_fall default to 0 on every edge.
  - They are never both high on one channel.
  - Each is high for exactly one cycle per accepted transition.
- Counter behaviour:
  - The counter never wraps; it saturates in practice because the terminal condition always clears it.
- Channel independence:
  - Channels share nothing but the clock and reset.
  - Simultaneous transitions on several channels are accepted in the same cycle if their histories match.
- Reset (i_rst_n low at a rising edge):
  - sync1, sync2, stable, cnt, o_switch, o_rise and o_fall are all cleared to 0.
  - Reset takes priority over every other update.
  - A reset asserted mid-count discards the partial count.
  - After reset release, a switch physically high is treated as a 0->1 transition and debounced normally. It produces an o_rise pulse.

## Timing
- Reset values: o_switch = 0, o_rise = 0, o_fall = 0.
- Latency:
  - Let E0 be the first rising edge at which sync1 samples a new stable level.
  - o_switch updates on edge E0+DEBOUNCE_CYCLES+1.
  - The matching o_rise/o_fall pulse is visible for the cycle following that same edge.
- Minimum accepted pulse width on i_switch: DEBOUNCE_CYCLES consecutive cycles at sync2. Anything shorter produces no output activity.
- Bounce during counting: any cycle where sync2 returns to the stable value restarts the count from 0. Latency is then measured from the last such cycle.
- All outputs are registered. There are no combinational paths from i_switch to any output.
- Single clock domain. i_switch is the only asynchronous input.

## Test plan
Run with NUM_SWITCHES=6 and DEBOUNCE_CYCLES=4 unless noted.
- Reset behaviour:
  - Stimulus: hold i_rst_n=0 for 3 cycles with i_switch=6'b111111, then release.
  - Required: o_switch=0 and o_rise=0 throughout reset.
  - Required: o_switch becomes 6'b111111 on edge E0+5, where E0 is the first edge after release.
  - Required: o_rise=6'b111111 for exactly one cycle, o_fall never asserted.
- Clean rise:
  - Stimulus: switch 0 goes 0->1 and is held.
  - Required: o_switch[0]=1 exactly 5 edges after E0, o_rise[0] high for one cycle, other bits unchanged.
- Glitch rejection:
  - Stimulus: switch 2 is high for 3 cycles, then low again.
  - Required: o_switch[2] stays 0 and o_rise[2]/o_fall[2] stay 0.
- Bounce then settle:
  - Stimulus: switch 1 toggles 1,0,1,1,0 (one cycle each), then holds 1.
  - Required: o_switch[1] rises 5 edges after the final 0->1 sample, with exactly one o_rise[1] pulse.
- Simultaneous and opposite transitions:
  - Stimulus: from o_switch=6'b000011, drive i_switch=6'b001100 on one edge.
  - Required: at E0+5, o_switch=6'b001100, o_rise=6'b001100 and o_fall=6'b000011, all in the same single cycle.
- Reset mid-count:
  - Stimulus: switch 5 rises; assert i_rst_n=0 for 1 cycle at count 2, then release.
  - Required: all outputs cleared on the reset edge, then o_switch[5] rises 5 edges after the first post-release edge.
